coord_rand_gen: RTL and testbench
=================================

# coord_rand_gen

Free-running pseudo-random grid-coordinate source for the snake playfield. It drives the `randX`/`randY` inputs of the obstacle generator, and of any other placement logic such as food. Every enabled cycle it advances a 16-bit Galois LFSR and rejection-samples an in-range candidate per axis. A bounded fallback mapping guarantees forward progress, and a one-cycle strobe marks each fully refreshed coordinate pair.

## Interface
- `SEED`, 16'hACE1, LFSR value after reset or after a zero seed load; must be non-zero.
- `MAX_X`, 14, largest legal X; legal X range is 1..MAX_X.
- `MAX_Y`, 10, largest legal Y; legal Y range is 1..MAX_Y.
- `REJECT_LIMIT`, 7, consecutive rejects per axis before a fallback value is forced; range 1..15.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `en`  in  1  advance the LFSR and sample this cycle.
- `seed_load`  in  1  load `seed` into the LFSR; has priority over `en`.
- `seed`  in  16  seed value.
- `randX`  out  4  current X coordinate; always within 1..MAX_X.
- `randY`  out  4  current Y coordinate; always within 1..MAX_Y.
- `coord_valid`  out  1  one-cycle pulse; the pair now on `randX`/`randY` has both axes updated since the previous pulse.

## Operation
- **LFSR**
  - Galois, right-shift, mask 16'hB400 (x^16+x^14+x^13+x^11+1).
  - Step rule: `next = lsb ? (lfsr>>1)^16'hB400 : lfsr>>1`.
- **Candidates** are taken from `next`, the post-step value:
  - `cx = next[3:0]`
  - `cy = next[11:8]`
- **Per-axis sampling** (the X and Y axes are independent):
  - Accept: if 1 ≤ c ≤ MAX, register c and clear that axis's reject counter.
  - Reject: otherwise increment the reject counter.
  - Fallback: if the incremented count equals REJECT_LIMIT, register `(c mod MAX)+1` and clear the counter.
    - mod is a single conditional subtract, valid because c ≤ 15 < 2·MAX.
  - A rejected axis with no fallback holds its output.
- **Fresh flags and `coord_valid`**
  - Each axis has a fresh flag, set whenever that axis output is updated.
  - `coord_valid` is registered: it is 1 in the cycle after the edge where `(x_upd | x_fresh) & (y_upd | y_fresh)`. That same edge clears both flags.
- **`seed_load`**
  - `lfsr <= (seed==16'h0) ? SEED : seed`.
  - Clears the reject counters and fresh flags; `coord_valid` goes to 0.
  - `randX`/`randY` hold their values.
- **`en=0`** (without `seed_load`): all state holds and `coord_valid=0`.
- **Reset values:**
  - `lfsr` = SEED
  - `randX` = 1, `randY` = 1
  - `coord_valid` = 0
  - counters and flags = 0
- The LFSR never reaches zero: zero seeds are substituted, and the step function maps non-zero to non-zero.

## Timing
- All outputs are registered. A step requested with `en` at edge N is visible on `randX`/`randY`/`coord_valid` after edge N.
- Throughput: one step per enabled cycle. Worst-case latency to a new per-axis value is REJECT_LIMIT enabled cycles.
- `coord_valid` is a single-cycle pulse. It never stays high two cycles in a row unless both axes update on consecutive edges.
- Simultaneous `seed_load` and `en`: only the load occurs, with no step.
- Reset asserted mid-operation clears state asynchronously. The first step after release uses SEED.

## Structure
- Shared package `snake_pkg` holds:
  - `GRID_W=14`, `GRID_H=10`
  - `coord_t` (4-bit)
  - `LFSR_MASK=16'hB400`
  - `DEFAULT_SEED`
- Sub-module `axis_sampler` (parameter MAX, REJECT_LIMIT) is instantiated twice.
  - Inputs: candidate, step.
  - Outputs: coordinate, update.
  - Contains the reject counter and the fallback mapping.
- The LFSR step is inline in the top module.

## Test plan
- **Reset, then `en=1` for 2 cycles:**
  - Edge 1: lfsr=16'hE270, cx=0 rejected → randX=1 held; cy=2 → randY=2; coord_valid=0.
  - Edge 2: lfsr=16'h7138 → randX=8, randY=1, coord_valid=1.
- **REJECT_LIMIT=1 override, reset, `en` for 1 cycle:** cx=0 forces fallback → randX=1, randY=2, coord_valid=1 after edge 1.
- **`seed_load=1`, `seed=0`, then `en` for 2 cycles:** lfsr=16'hACE1; the sequence repeats the first scenario exactly (randX=8, randY=1 after the second step).
- **`seed_load` and `en` high together:** LFSR equals the loaded seed with no step; outputs hold; coord_valid=0.
- **10 000 random `en`/`seed_load` cycles with a scoreboard model:**
  - randX always in 1..14 and randY always in 1..10.
  - Never more than REJECT_LIMIT enabled cycles without a per-axis update.
  - lfsr never 0.
- **Assert `rst` mid-stream with `en=1`:** outputs are 1/1/0 immediately, and the first post-release step gives lfsr=16'hE270.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared playfield constants and coordinate helpers for the snake design.
package snake_pkg;

    localparam int unsigned GRID_W  = 14;
    localparam int unsigned GRID_H  = 10;
    localparam int unsigned COORD_W = 4;

    typedef logic [COORD_W-1:0] coord_t;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int unsigned DEFAULT_REJECT_LIMIT = 7;

    // Single conditional subtract suffices because a 4-bit candidate is below 2*maxVal.
    function automatic coord_t wrapCoord(coord_t c, coord_t maxVal);
        coord_t m;
        m = (c >= maxVal) ? coord_t'(c - maxVal) : c;
        return coord_t'(m + 1'b1);
    endfunction

endpackage

// File: rtl/coord_rand_gen_if.sv
// Control and coordinate bus between a placement consumer and coord_rand_gen.
interface coord_rand_gen_if;
    import snake_pkg::*;

    logic        en;
    logic        seed_load;
    logic [15:0] seed;
    coord_t      randX;
    coord_t      randY;
    logic        coord_valid;

    modport master (
        output en,
        output seed_load,
        output seed,
        input  randX,
        input  randY,
        input  coord_valid
    );

    modport slave (
        input  en,
        input  seed_load,
        input  seed,
        output randX,
        output randY,
        output coord_valid
    );

endinterface

// File: rtl/coord_rand_gen_axis_sampler.sv
// Per-axis rejection sampler: accepts in-range candidates, forces a wrapped
// fallback after REJECT_LIMIT consecutive rejects.
module axis_sampler
    import snake_pkg::*;
#(
    parameter int unsigned MAX          = GRID_W,
    parameter int unsigned REJECT_LIMIT = DEFAULT_REJECT_LIMIT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   step,
    input  coord_t candidate,
    output coord_t coord,
    output logic   update
);

    localparam coord_t     MAX_C   = coord_t'(MAX);
    localparam logic [3:0] LIMIT_C = 4'(REJECT_LIMIT);

    logic [3:0] rejectCnt;
    logic [3:0] rejectInc;
    logic [3:0] rejectCntNext;
    logic       accept;
    logic       fallback;
    coord_t     coordNext;

    always_comb begin
        accept        = (candidate != '0) && (candidate <= MAX_C);
        rejectInc     = rejectCnt + 4'd1;
        fallback      = !accept && (rejectInc == LIMIT_C);
        update        = step && (accept || fallback);
        coordNext     = accept ? candidate : wrapCoord(candidate, MAX_C);
        rejectCntNext = (accept || fallback) ? '0 : rejectInc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coord     <= coord_t'(1);
            rejectCnt <= '0;
        end else if (clr) begin
            rejectCnt <= '0;
        end else if (step) begin
            rejectCnt <= rejectCntNext;
            if (update) begin
                coord <= coordNext;
            end
        end
    end

endmodule

// File: rtl/coord_rand_gen.sv
// Free-running LFSR-driven grid coordinate source with per-axis rejection
// sampling and a strobe marking each fully refreshed X/Y pair.
module coord_rand_gen
    import snake_pkg::*;
#(
    parameter logic [15:0] SEED         = DEFAULT_SEED,
    parameter int unsigned MAX_X        = GRID_W,
    parameter int unsigned MAX_Y        = GRID_H,
    parameter int unsigned REJECT_LIMIT = DEFAULT_REJECT_LIMIT
) (
    input logic             clk,
    input logic             rst,
    coord_rand_gen_if.slave bus
);

    logic [15:0] lfsr;
    logic [15:0] lfsrNext;
    logic        step;
    logic        xUpd;
    logic        yUpd;
    logic        xFresh;
    logic        yFresh;
    logic        pairDone;
    logic        coordValid;
    coord_t      xCoord;
    coord_t      yCoord;

    always_comb begin
        step     = bus.en && !bus.seed_load;
        lfsrNext = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
        pairDone = (xUpd || xFresh) && (yUpd || yFresh);
    end

    axis_sampler #(
        .MAX          (MAX_X),
        .REJECT_LIMIT (REJECT_LIMIT)
    ) xAxis (
        .clk       (clk),
        .rst       (rst),
        .clr       (bus.seed_load),
        .step      (step),
        .candidate (lfsrNext[3:0]),
        .coord     (xCoord),
        .update    (xUpd)
    );

    axis_sampler #(
        .MAX          (MAX_Y),
        .REJECT_LIMIT (REJECT_LIMIT)
    ) yAxis (
        .clk       (clk),
        .rst       (rst),
        .clr       (bus.seed_load),
        .step      (step),
        .candidate (lfsrNext[11:8]),
        .coord     (yCoord),
        .update    (yUpd)
    );

    // A zero seed is swapped for SEED so the LFSR can never lock up at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr       <= SEED;
            xFresh     <= 1'b0;
            yFresh     <= 1'b0;
            coordValid <= 1'b0;
        end else if (bus.seed_load) begin
            lfsr       <= (bus.seed == 16'h0) ? SEED : bus.seed;
            xFresh     <= 1'b0;
            yFresh     <= 1'b0;
            coordValid <= 1'b0;
        end else if (bus.en) begin
            lfsr <= lfsrNext;
            if (pairDone) begin
                xFresh     <= 1'b0;
                yFresh     <= 1'b0;
                coordValid <= 1'b1;
            end else begin
                xFresh     <= xFresh || xUpd;
                yFresh     <= yFresh || yUpd;
                coordValid <= 1'b0;
            end
        end else begin
            coordValid <= 1'b0;
        end
    end

    assign bus.randX       = xCoord;
    assign bus.randY       = yCoord;
    assign bus.coord_valid = coordValid;

endmodule

// File: tb/tb_coord_rand_gen.sv
// Bench for coord_rand_gen: directed vectors plus a spec-level reference model.
module tb_coord_rand_gen;

    localparam int LIM   = 7;
    localparam int MAXX  = 14;
    localparam int MAXY  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    coord_rand_gen_if bus ();
    coord_rand_gen_if bus2 ();

    coord_rand_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    coord_rand_gen #(
        .REJECT_LIMIT (1)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        int val;
        int cnt;
        bit upd;
    } axis_t;

    typedef struct {
        logic [15:0] lfsr;
        axis_t       ax;
        axis_t       ay;
        bit          fx;
        bit          fy;
        bit          valid;
    } model_t;

    model_t m;

    function automatic model_t resetModel();
        model_t r;
        r.lfsr   = 16'hACE1;
        r.ax.val = 1; r.ax.cnt = 0; r.ax.upd = 0;
        r.ay.val = 1; r.ay.cnt = 0; r.ay.upd = 0;
        r.fx = 0; r.fy = 0; r.valid = 0;
        return r;
    endfunction

    function automatic axis_t sampleAxis(axis_t a, int c, int mx);
        axis_t r = a;
        r.upd = 0;
        if (c >= 1 && c <= mx) begin
            r.val = c; r.cnt = 0; r.upd = 1;
        end else begin
            r.cnt = r.cnt + 1;
            if (r.cnt == LIM) begin
                r.val = (c % mx) + 1; r.cnt = 0; r.upd = 1;
            end
        end
        return r;
    endfunction

    function automatic model_t nextModel(model_t cur, bit en, bit ld, logic [15:0] sd);
        model_t      r = cur;
        logic [15:0] n;
        r.valid = 0;
        if (ld) begin
            r.lfsr = (sd == 16'h0) ? 16'hACE1 : sd;
            r.ax.cnt = 0; r.ay.cnt = 0;
            r.fx = 0; r.fy = 0;
        end else if (en) begin
            n = cur.lfsr >> 1;
            if (cur.lfsr[0]) n = n ^ 16'hB400;
            r.lfsr = n;
            r.ax = sampleAxis(cur.ax, int'(n[3:0]), MAXX);
            r.ay = sampleAxis(cur.ay, int'(n[11:8]), MAXY);
            if ((r.ax.upd || cur.fx) && (r.ay.upd || cur.fy)) begin
                r.valid = 1; r.fx = 0; r.fy = 0;
            end else begin
                r.fx = cur.fx || r.ax.upd;
                r.fy = cur.fy || r.ay.upd;
            end
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= resetModel();
        else     m <= nextModel(m, bus.en, bus.seed_load, bus.seed);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic compareModel();
        chk("model randX", int'(bus.randX), m.ax.val);
        chk("model randY", int'(bus.randY), m.ay.val);
        chk("model coord_valid", int'(bus.coord_valid), int'(m.valid));
        chk("model lfsr", int'(dut.lfsr), int'(m.lfsr));
        chk("randX range", int'(bus.randX >= 1 && bus.randX <= 14), 1);
        chk("randY range", int'(bus.randY >= 1 && bus.randY <= 10), 1);
        chk("lfsr nonzero", int'(dut.lfsr != 16'h0), 1);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        compareModel();
    endtask

    initial begin
        bus.en = 0; bus.seed_load = 0; bus.seed = 16'h0;
        bus2.en = 0; bus2.seed_load = 0; bus2.seed = 16'h0;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        compareModel();
        chk("reset randX", int'(bus.randX), 1);
        chk("reset randY", int'(bus.randY), 1);
        chk("reset valid", int'(bus.coord_valid), 0);
        chk("reset lfsr", int'(dut.lfsr), 16'hACE1);

        // first scenario, plus REJECT_LIMIT=1 instance in parallel
        bus.en = 1; bus2.en = 1;
        cycle();
        chk("e1 lfsr", int'(dut.lfsr), 16'hE270);
        chk("e1 randX", int'(bus.randX), 1);
        chk("e1 randY", int'(bus.randY), 2);
        chk("e1 valid", int'(bus.coord_valid), 0);
        chk("lim1 randX", int'(bus2.randX), 1);
        chk("lim1 randY", int'(bus2.randY), 2);
        chk("lim1 valid", int'(bus2.coord_valid), 1);
        bus2.en = 0;
        cycle();
        chk("e2 lfsr", int'(dut.lfsr), 16'h7138);
        chk("e2 randX", int'(bus.randX), 8);
        chk("e2 randY", int'(bus.randY), 1);
        chk("e2 valid", int'(bus.coord_valid), 1);

        bus.en = 0;
        cycle();
        chk("idle valid", int'(bus.coord_valid), 0);
        chk("idle randX", int'(bus.randX), 8);
        chk("idle lfsr", int'(dut.lfsr), 16'h7138);

        // zero seed load restores SEED, then sequence repeats
        bus.seed_load = 1; bus.seed = 16'h0;
        cycle();
        chk("zload lfsr", int'(dut.lfsr), 16'hACE1);
        chk("zload randX", int'(bus.randX), 8);
        chk("zload randY", int'(bus.randY), 1);
        bus.seed_load = 0; bus.en = 1;
        cycle();
        chk("zl e1 randY", int'(bus.randY), 2);
        chk("zl e1 valid", int'(bus.coord_valid), 0);
        cycle();
        chk("zl e2 randX", int'(bus.randX), 8);
        chk("zl e2 randY", int'(bus.randY), 1);
        chk("zl e2 valid", int'(bus.coord_valid), 1);

        // load wins over en: no step
        bus.seed_load = 1; bus.seed = 16'h1234; bus.en = 1;
        cycle();
        chk("ld+en lfsr", int'(dut.lfsr), 16'h1234);
        chk("ld+en randX", int'(bus.randX), 8);
        chk("ld+en randY", int'(bus.randY), 1);
        chk("ld+en valid", int'(bus.coord_valid), 0);
        bus.seed_load = 0;

        for (int i = 0; i < 10000; i++) begin
            bus.en        = ($urandom_range(0, 3) != 0);
            bus.seed_load = ($urandom_range(0, 63) == 0);
            bus.seed      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            cycle();
        end

        // async reset mid-stream
        bus.en = 1; bus.seed_load = 0;
        #2 rst = 1;
        #1;
        compareModel();
        chk("arst randX", int'(bus.randX), 1);
        chk("arst randY", int'(bus.randY), 1);
        chk("arst valid", int'(bus.coord_valid), 0);
        chk("arst lfsr", int'(dut.lfsr), 16'hACE1);
        cycle();
        rst = 0;
        cycle();
        chk("post-rst lfsr", int'(dut.lfsr), 16'hE270);
        chk("post-rst randY", int'(bus.randY), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
